rectangle_dec: RTL
==================

Name: rectangle_dec

Overview:
RECTANGLE-128 round-based decryption core. It is the inverse of the round-based encryption core and uses the same 64-bit state layout (4 rows × 16 bits) and 128-bit key layout (4 rows × 32 bits). It first runs the key schedule forward to recover the last round key, then runs 25 inverse rounds, one per cycle, regenerating each earlier round key on the fly.

Parameters:
ROUNDS, 25, number of cipher rounds; also the number of forward key-update cycles.
RC_INIT, 5'h01, round-constant LFSR seed RC[0].

Ports:
i_clk  input  1  clock; all registers update on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_start  input  1  single-cycle request; accepted only in IDLE or DONE.
iv_ciphertext  input  64  ciphertext; row r = bits [16r+15:16r].
iv_key  input  128  master key; row r = bits [32r+31:32r].
o_busy  output  1  high in EXPAND and DECRYPT.
o_done  output  1  one-cycle pulse; ov_data is valid in that cycle.
ov_data  output  64  plaintext, registered, held until the next o_done.

Behaviour:
- Reset values:
  - FSM = IDLE; o_busy = 0; o_done = 0; ov_data = 0.
  - State, key, rc and counter registers are all 0.
- Reset is asynchronous and can occur in any state. Mid-operation it aborts the operation with no o_done.
- Round key Ki = bits [15:0] of each of the 4 key rows after i forward updates.
- Forward key update, using rc:
  - Apply the S-box to key columns 0..7.
  - Row feistel: R0' = (R0<<<8)^R1, R1' = R2, R2' = (R2<<<16)^R3, R3' = R0.
  - R0'[4:0] ^= rc.
- Inverse key update, using rc:
  - Undo the RC XOR on R0.
  - R0 = R3', R2 = R1', R1 = R0' ^ (R0<<<8), R3 = R2' ^ (R2<<<16).
  - Apply the inverse S-box to columns 0..7.
- LFSR: rc_next = {rc[3:0], rc[4]^rc[2]}. The inverse LFSR is its exact inverse.
- Inverse ShiftRow: row1 >>>1, row2 >>>12, row3 >>>13; row0 is unchanged.
- FSM:
  - IDLE/DONE + i_start:
    - Load state ← iv_ciphertext, key ← iv_key, rc ← RC_INIT, cnt ← 0.
    - Go to EXPAND.
  - DONE without i_start: go to IDLE.
  - EXPAND, every cycle: key ← fwd_update(key, rc).
    - cnt < ROUNDS-1: rc ← lfsr(rc), cnt++.
    - cnt == ROUNDS-1: rc is held (it then holds RC[24]) and the FSM goes to DECRYPT.
  - DECRYPT, every cycle:
    - state ← invSbox(invShiftRow(state ^ Kcur)).
    - key ← inv_update(key, rc); rc ← inv_lfsr(rc); cnt--.
  - DECRYPT, last cycle (cnt == 0):
    - ov_data ← next_state ^ K0, where K0 is taken from the next key value.
    - Go to DONE; o_done = 1.
- After completion the key register equals iv_key exactly. This is an internal check point for verification.
- Latency: i_start sampled at edge 0 → EXPAND on edges 1..25 → DECRYPT on edges 26..50 → o_done high between edges 50 and 51.
  - Back-to-back: i_start in the DONE cycle starts the next operation with no idle cycle.
- i_start while busy is ignored. iv_ciphertext and iv_key are sampled only at acceptance and may change afterwards.
- Boundary cases:
  - ROUNDS-1 wrap: the counter never underflows; DECRYPT exits at cnt == 0.
  - Reset asserted in the same cycle as i_start: reset wins.

Decomposition:
- rectangle_pkg holds:
  - constants ROUNDS and RC_INIT;
  - functions sbox, inv_sbox, shift_row, inv_shift_row, key_update, inv_key_update, lfsr, inv_lfsr.
  - The encryption core migrates to the same functions.
- Sub-module rectangle_inv_key_sched holds the key and rc registers with fwd/inv step controls and a Kcur output.
- The top level holds the FSM, counter, state datapath and output register.

Test Plan:
1. Key 128'h0, ciphertext = golden-model encryption of 64'h0 → ov_data = 64'h0 with o_done on edge 50; key register = 0.
2. Key 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, plaintext 64'hFFFF_FFFF_FFFF_FFFF encrypted by the encryption core → round-trip ov_data = 64'hFFFF_FFFF_FFFF_FFFF; o_busy high for exactly 50 cycles.
3. 1000 random key/plaintext pairs chained enc → dec, back-to-back with i_start in the DONE cycle → every ov_data equals its plaintext; zero idle cycles between operations.
4. i_start re-pulsed at cycles 5 and 30 with different inputs → ignored; result matches the first request only.
5. i_rst asserted at cycle 20 of DECRYPT → o_busy = 0, o_done = 0 and ov_data = 0 immediately; the next request completes correctly.
6. Inputs changed on the cycle after acceptance → result unaffected; o_done pulse width exactly 1 cycle.

Source files
------------

// File: rtl/rectangle_dec_pkg.sv
// Shared RECTANGLE-128 definitions: cipher constants, FSM state type and the
// S-box, row-shift, key-schedule and round-constant helpers used by both the
// encryption and decryption cores.
package rectangle_pkg;

    localparam int         ROUNDS  = 25;
    localparam logic [4:0] RC_INIT = 5'h01;

    localparam int                 CNT_W    = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DECRYPT,
        ST_DONE
    } dec_state_t;

    // 4-bit S-box; input bit i comes from row i of one column.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
            4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
            4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
            4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hF;  4'h3: y = 4'hA;
            4'h4: y = 4'hE;  4'h5: y = 4'h1;  4'h6: y = 4'h0;  4'h7: y = 4'h6;
            4'h8: y = 4'hC;  4'h9: y = 4'h7;  4'hA: y = 4'h3;  4'hB: y = 4'h8;
            4'hC: y = 4'h2;  4'hD: y = 4'hB;  4'hE: y = 4'h5;  default: y = 4'hD;
        endcase
        return y;
    endfunction

    // Column-wise S-box over all 16 columns of the 4x16 state.
    function automatic logic [63:0] sub_column(input logic [63:0] s);
        logic [63:0] r;
        logic [3:0]  c;
        r = s;
        for (int j = 0; j < 16; j++) begin
            c = sbox({s[48+j], s[32+j], s[16+j], s[j]});
            {r[48+j], r[32+j], r[16+j], r[j]} = c;
        end
        return r;
    endfunction

    function automatic logic [63:0] inv_sub_column(input logic [63:0] s);
        logic [63:0] r;
        logic [3:0]  c;
        r = s;
        for (int j = 0; j < 16; j++) begin
            c = inv_sbox({s[48+j], s[32+j], s[16+j], s[j]});
            {r[48+j], r[32+j], r[16+j], r[j]} = c;
        end
        return r;
    endfunction

    // Row rotations: row1 <<<1, row2 <<<12, row3 <<<13.
    function automatic logic [63:0] shift_row(input logic [63:0] s);
        return {s[50:48], s[63:51], s[35:32], s[47:36], s[30:16], s[31], s[15:0]};
    endfunction

    function automatic logic [63:0] inv_shift_row(input logic [63:0] s);
        return {s[60:48], s[63:61], s[43:32], s[47:44], s[16], s[31:17], s[15:0]};
    endfunction

    // S-box over key columns 0..7 only (32-bit rows).
    function automatic logic [127:0] key_sub(input logic [127:0] k, input bit inverse);
        logic [127:0] r;
        logic [3:0]   c;
        r = k;
        for (int j = 0; j < 8; j++) begin
            c = {k[96+j], k[64+j], k[32+j], k[j]};
            c = inverse ? inv_sbox(c) : sbox(c);
            {r[96+j], r[64+j], r[32+j], r[j]} = c;
        end
        return r;
    endfunction

    function automatic logic [127:0] key_update(input logic [127:0] k, input logic [4:0] rc);
        logic [127:0] t;
        logic [31:0]  r0, r1, r2, r3, n0;
        t  = key_sub(k, 1'b0);
        r0 = t[31:0];
        r1 = t[63:32];
        r2 = t[95:64];
        r3 = t[127:96];
        n0 = {r0[23:0], r0[31:24]} ^ r1;
        n0[4:0] = n0[4:0] ^ rc;
        return {r0, {r2[15:0], r2[31:16]} ^ r3, r2, n0};
    endfunction

    function automatic logic [127:0] inv_key_update(input logic [127:0] k, input logic [4:0] rc);
        logic [31:0] n0, r0, r1, r2, r3;
        n0 = k[31:0] ^ {27'd0, rc};
        r0 = k[127:96];
        r2 = k[63:32];
        r1 = n0 ^ {r0[23:0], r0[31:24]};
        r3 = k[95:64] ^ {r2[15:0], r2[31:16]};
        return key_sub({r3, r2, r1, r0}, 1'b1);
    endfunction

    function automatic logic [4:0] lfsr(input logic [4:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

    // Shifted-out bit rc[4] is recovered from the feedback bit and rc[2] (now at bit 3).
    function automatic logic [4:0] inv_lfsr(input logic [4:0] rc);
        return {rc[0] ^ rc[3], rc[4:1]};
    endfunction

endpackage

// File: rtl/rectangle_dec_if.sv
// Request/response bundle of the RECTANGLE-128 decryption core.
interface rectangle_dec_if;
    logic         i_start;
    logic [63:0]  iv_ciphertext;
    logic [127:0] iv_key;
    logic         o_busy;
    logic         o_done;
    logic [63:0]  ov_data;

    modport master (
        output i_start, iv_ciphertext, iv_key,
        input  o_busy, o_done, ov_data
    );

    modport slave (
        input  i_start, iv_ciphertext, iv_key,
        output o_busy, o_done, ov_data
    );
endinterface

// File: rtl/rectangle_dec_key_sched.sv
// Key and round-constant registers; steps the schedule forward during
// expansion and backward during decryption, exposing the current round key
// and the round key that the next backward step will produce.
module rectangle_inv_key_sched
    import rectangle_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         fwd_step,
    input  logic         fwd_rc_adv,
    input  logic         inv_step,
    input  logic [127:0] key_in,
    output logic [63:0]  round_key,
    output logic [63:0]  round_key_after_inv
);

    logic [127:0] key_reg;
    logic [4:0]   rc_reg;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;

    assign key_fwd = key_update(key_reg, rc_reg);
    assign key_inv = inv_key_update(key_reg, rc_reg);

    // Round key = low 16 bits of each 32-bit key row.
    for (genvar gi = 0; gi < 4; gi++) begin : g_round_key
        assign round_key[16*gi +: 16]           = key_reg[32*gi +: 16];
        assign round_key_after_inv[16*gi +: 16] = key_inv[32*gi +: 16];
    end

    // Load on acceptance, otherwise walk the schedule in the requested direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
            rc_reg  <= '0;
        end else if (load) begin
            key_reg <= key_in;
            rc_reg  <= RC_INIT;
        end else if (fwd_step) begin
            key_reg <= key_fwd;
            if (fwd_rc_adv) begin
                rc_reg <= lfsr(rc_reg);
            end
        end else if (inv_step) begin
            key_reg <= key_inv;
            rc_reg  <= inv_lfsr(rc_reg);
        end
    end

endmodule

// File: rtl/rectangle_dec.sv
// RECTANGLE-128 round-based decryption core: expands the key to the last
// round key, then runs one inverse round per cycle while stepping the key
// schedule backwards.
module rectangle_dec
    import rectangle_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    rectangle_dec_if.slave bus
);

    dec_state_t       fsm_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0]      state_reg;
    logic [63:0]      data_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             accept;
    logic [63:0]      round_key;
    logic [63:0]      round_key_after_inv;
    logic [63:0]      dec_next;

    assign accept   = ((fsm_reg == ST_IDLE) || (fsm_reg == ST_DONE)) && bus.i_start;
    assign dec_next = inv_sub_column(inv_shift_row(state_reg ^ round_key));

    rectangle_inv_key_sched u_key_sched (
        .clk                 (i_clk),
        .rst                 (i_rst),
        .load                (accept),
        .fwd_step            (fsm_reg == ST_EXPAND),
        .fwd_rc_adv          ((fsm_reg == ST_EXPAND) && (cnt_reg != CNT_LAST)),
        .inv_step            (fsm_reg == ST_DECRYPT),
        .key_in              (bus.iv_key),
        .round_key           (round_key),
        .round_key_after_inv (round_key_after_inv)
    );

    // Control FSM, round counter, state datapath and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm_reg   <= ST_IDLE;
            cnt_reg   <= '0;
            state_reg <= '0;
            data_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_reg <= bus.iv_ciphertext;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= ST_EXPAND;
                    end else begin
                        fsm_reg   <= ST_IDLE;
                    end
                end
                ST_EXPAND: begin
                    // The last expansion step leaves cnt at ROUNDS-1, ready to count down.
                    if (cnt_reg == CNT_LAST) begin
                        fsm_reg <= ST_DECRYPT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DECRYPT: begin
                    state_reg <= dec_next;
                    if (cnt_reg == '0) begin
                        // Final whitening uses K0, which the key schedule produces this cycle.
                        data_reg <= dec_next ^ round_key_after_inv;
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                        fsm_reg  <= ST_DONE;
                    end else begin
                        cnt_reg  <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    fsm_reg  <= ST_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy  = busy_reg;
    assign bus.o_done  = done_reg;
    assign bus.ov_data = data_reg;

endmodule
